// File: rtl/sevenseg_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit order,
// active-high glyphs for hex digits, scan FSM states and a counter sizing helper.
package sevenseg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] M_A = 7'(1 << SEG_A);
  localparam logic [6:0] M_B = 7'(1 << SEG_B);
  localparam logic [6:0] M_C = 7'(1 << SEG_C);
  localparam logic [6:0] M_D = 7'(1 << SEG_D);
  localparam logic [6:0] M_E = 7'(1 << SEG_E);
  localparam logic [6:0] M_F = 7'(1 << SEG_F);
  localparam logic [6:0] M_G = 7'(1 << SEG_G);

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_0 = M_A | M_B | M_C | M_D | M_E | M_F;
  localparam logic [6:0] SEG_1 = M_B | M_C;
  localparam logic [6:0] SEG_2 = M_A | M_B | M_D | M_E | M_G;
  localparam logic [6:0] SEG_3 = M_A | M_B | M_C | M_D | M_G;
  localparam logic [6:0] SEG_4 = M_B | M_C | M_F | M_G;
  localparam logic [6:0] SEG_5 = M_A | M_C | M_D | M_F | M_G;
  localparam logic [6:0] SEG_6 = M_A | M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] SEG_7 = M_A | M_B | M_C;
  localparam logic [6:0] SEG_8 = M_A | M_B | M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] SEG_9 = M_A | M_B | M_C | M_D | M_F | M_G;
  localparam logic [6:0] SEG_HA = M_A | M_B | M_C | M_E | M_F | M_G;
  localparam logic [6:0] SEG_HB = M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] SEG_HC = M_A | M_D | M_E | M_F;
  localparam logic [6:0] SEG_HD = M_B | M_C | M_D | M_E | M_G;
  localparam logic [6:0] SEG_HE = M_A | M_D | M_E | M_F | M_G;
  localparam logic [6:0] SEG_HF = M_A | M_E | M_F | M_G;

  typedef enum logic {
    ST_LIT = 1'b0,
    ST_GAP = 1'b1
  } scan_state_e;

  function automatic int cnt_width(input int digit_cycles, input int gap_cycles);
    int m;
    m = 2;
    if (digit_cycles > m) m = digit_cycles;
    if (gap_cycles > m) m = gap_cycles;
    return $clog2(m);
  endfunction

endpackage

// File: rtl/sevenseg_decode.sv
// Nibble to active-high segment pattern; a dark request overrides the glyph.
module sevenseg_decode
  import sevenseg_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg_on
);

  always_comb begin
    seg_on = SEG_BLANK;
    if (!blank) begin
      case (nibble)
        4'h0: seg_on = SEG_0;
        4'h1: seg_on = SEG_1;
        4'h2: seg_on = SEG_2;
        4'h3: seg_on = SEG_3;
        4'h4: seg_on = SEG_4;
        4'h5: seg_on = SEG_5;
        4'h6: seg_on = SEG_6;
        4'h7: seg_on = SEG_7;
        4'h8: seg_on = SEG_8;
        4'h9: seg_on = SEG_9;
        4'hA: seg_on = SEG_HA;
        4'hB: seg_on = SEG_HB;
        4'hC: seg_on = SEG_HC;
        4'hD: seg_on = SEG_HD;
        4'hE: seg_on = SEG_HE;
        4'hF: seg_on = SEG_HF;
      endcase
    end
  end

endmodule

// File: rtl/sevenseg_scan_mux.sv
// Time-multiplexed 7-segment driver: frame-synchronous double buffer, leading-zero
// blanking and an all-dark gap between digits to avoid ghosting.
module sevenseg_scan_mux
  import sevenseg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIGIT_CYCLES   = 50000,
  parameter int GAP_CYCLES     = 16,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] hex_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_in,
  input  logic                    lzb_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_start
);

  localparam int CNT_W = cnt_width(DIGIT_CYCLES, GAP_CYCLES);
  localparam int IDX_W = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CNT_W-1:0]      LIT_LOAD = CNT_W'(DIGIT_CYCLES - 1);
  localparam logic [CNT_W-1:0]      GAP_LOAD = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [6:0]            SEG_OFF  = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic                  DP_OFF   = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AN_OFF   = AN_ACTIVE_LOW ? '1 : '0;

  scan_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;

  logic [4*NUM_DIGITS-1:0] pend_hex_q, pend_hex_d;
  logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic [NUM_DIGITS-1:0]   pend_blank_q, pend_blank_d;
  logic                    pend_valid_q, pend_valid_d;
  logic [4*NUM_DIGITS-1:0] act_hex_q, act_hex_d;
  logic [NUM_DIGITS-1:0]   act_dp_q, act_dp_d;
  logic [NUM_DIGITS-1:0]   act_blank_q, act_blank_d;

  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic                    frame_start_q, frame_start_d;

  logic                    enter_first;
  logic                    transfer;
  logic [NUM_DIGITS-1:0]   suppress;
  logic [3:0]              nib_sel;
  logic                    dark_sel;
  logic                    dp_sel;
  logic [NUM_DIGITS-1:0]   an_onehot;
  logic [6:0]              seg_on;
  logic                    lit_d;

  // A transition happens only when the running count has expired; en freezes everything.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    if (en) begin
      if (cnt_q != '0) begin
        cnt_d = cnt_q - 1'b1;
      end else if (state_q == ST_LIT && GAP_CYCLES > 0) begin
        state_d = ST_GAP;
        cnt_d   = GAP_LOAD;
      end else begin
        state_d = ST_LIT;
        cnt_d   = LIT_LOAD;
        idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
      end
    end
  end

  assign enter_first = en && (cnt_q == '0) && (state_d == ST_LIT) && (idx_d == '0);
  assign transfer    = enter_first && pend_valid_q;

  always_comb begin
    act_hex_d    = transfer ? pend_hex_q   : act_hex_q;
    act_dp_d     = transfer ? pend_dp_q    : act_dp_q;
    act_blank_d  = transfer ? pend_blank_q : act_blank_q;
    pend_hex_d   = load ? hex_in   : pend_hex_q;
    pend_dp_d    = load ? dp_in    : pend_dp_q;
    pend_blank_d = load ? blank_in : pend_blank_q;
    pend_valid_d = load | (pend_valid_q & ~transfer);
  end

  // Walk down from the most significant digit while every nibble is zero without a dp.
  always_comb begin : lzb_chain
    logic run;
    suppress = '0;
    run      = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      run         = run && (act_hex_d[4*i +: 4] == 4'h0) && !act_dp_d[i];
      suppress[i] = lzb_en && run && (i != 0);
    end
  end

  always_comb begin
    nib_sel   = 4'h0;
    dark_sel  = 1'b1;
    dp_sel    = 1'b0;
    an_onehot = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_d == IDX_W'(i)) begin
        nib_sel      = act_hex_d[4*i +: 4];
        dark_sel     = act_blank_d[i] | suppress[i];
        dp_sel       = act_dp_d[i] & ~act_blank_d[i];
        an_onehot[i] = 1'b1;
      end
    end
  end

  sevenseg_decode u_decode (
    .nibble (nib_sel),
    .blank  (dark_sel),
    .seg_on (seg_on)
  );

  // Outputs are derived from the next state so anodes and segments switch together.
  always_comb begin
    lit_d         = en && (state_d == ST_LIT);
    seg_d         = lit_d ? (seg_on ^ SEG_OFF) : SEG_OFF;
    dp_d          = lit_d ? (dp_sel ^ DP_OFF) : DP_OFF;
    an_d          = lit_d ? (an_onehot ^ AN_OFF) : AN_OFF;
    frame_start_d = enter_first;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_GAP;
      idx_q         <= IDX_LAST;
      cnt_q         <= '0;
      pend_hex_q    <= '0;
      pend_dp_q     <= '0;
      pend_blank_q  <= '1;
      pend_valid_q  <= 1'b0;
      act_hex_q     <= '0;
      act_dp_q      <= '0;
      act_blank_q   <= '1;
      seg_q         <= SEG_OFF;
      dp_q          <= DP_OFF;
      an_q          <= AN_OFF;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      cnt_q         <= cnt_d;
      pend_hex_q    <= pend_hex_d;
      pend_dp_q     <= pend_dp_d;
      pend_blank_q  <= pend_blank_d;
      pend_valid_q  <= pend_valid_d;
      act_hex_q     <= act_hex_d;
      act_dp_q      <= act_dp_d;
      act_blank_q   <= act_blank_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      an_q          <= an_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg         = seg_q;
  assign dp          = dp_q;
  assign an          = an_q;
  assign frame_start = frame_start_q;

endmodule
